// File: rtl/mem_stage.sv
// MIPS32 memory stage: one load/store per instruction over a req/ack port, lane steering and load extension.
// Registered WB beat 1 cycle after accept (non-memory/exception) or 1 cycle after ack; in_ready low while an access is outstanding.
module mem_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  memop,
   input  logic [31:0] result,
   input  logic [31:0] store_data,
   input  logic        wreg_en,
   input  logic [4:0]  wreg_addr,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        out_valid,
   output logic        out_wreg_en,
   output logic [4:0]  out_wreg_addr,
   output logic [31:0] out_wdata,
   output logic        out_adel,
   output logic        out_ades,
   output logic [31:0] out_badvaddr
);

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LBU = 4'd2;
   localparam logic [3:0] OP_LH  = 4'd3;
   localparam logic [3:0] OP_LHU = 4'd4;
   localparam logic [3:0] OP_LW  = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   typedef enum logic {IDLE, ACCESS} state_t;

   typedef struct packed {
      logic [3:0] op;
      logic [1:0] off;
      logic       wreg_en;
      logic [4:0] wreg_addr;
   } acc_t;

   state_t      state, state_d;
   acc_t        acc;
   logic        accept, is_load, is_store, misal, acc_store;
   logic [3:0]  be_d;
   logic [31:0] wdata_d, ld_val;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign in_ready = (state == IDLE);
   assign accept   = in_valid && in_ready;

   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      misal    = 1'b0;
      be_d     = 4'b1111;
      wdata_d  = store_data;
      case (memop)
         OP_LB, OP_LBU: is_load = 1'b1;
         OP_LH, OP_LHU: begin
            is_load = 1'b1;
            misal   = result[0];
         end
         OP_LW: begin
            is_load = 1'b1;
            misal   = |result[1:0];
         end
         OP_SB: begin
            is_store = 1'b1;
            be_d     = 4'b0001 << result[1:0];
            wdata_d  = {4{store_data[7:0]}};
         end
         OP_SH: begin
            is_store = 1'b1;
            misal    = result[0];
            be_d     = result[1] ? 4'b1100 : 4'b0011;
            wdata_d  = {2{store_data[15:0]}};
         end
         OP_SW: begin
            is_store = 1'b1;
            misal    = |result[1:0];
         end
         default: ;
      endcase
   end

   // Load lane select uses the byte offset latched at accept, not the (aligned) bus address.
   always_comb begin
      byte_sel  = dmem_rdata[{acc.off, 3'b000} +: 8];
      half_sel  = acc.off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      acc_store = (acc.op == OP_SB) || (acc.op == OP_SH) || (acc.op == OP_SW);
      case (acc.op)
         OP_LB:   ld_val = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  ld_val = {24'd0, byte_sel};
         OP_LH:   ld_val = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  ld_val = {16'd0, half_sel};
         default: ld_val = dmem_rdata;
      endcase
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (accept && (is_load || is_store) && !misal) state_d = ACCESS;
         ACCESS:  if (dmem_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc           <= '0;
         dmem_req      <= 1'b0;
         dmem_we       <= 1'b0;
         dmem_be       <= 4'b0000;
         dmem_addr     <= 32'd0;
         dmem_wdata    <= 32'd0;
         out_valid     <= 1'b0;
         out_wreg_en   <= 1'b0;
         out_wreg_addr <= 5'd0;
         out_wdata     <= 32'd0;
         out_adel      <= 1'b0;
         out_ades      <= 1'b0;
         out_badvaddr  <= 32'd0;
      end else begin
         out_valid <= 1'b0;
         if (state == IDLE && accept) begin
            if (!(is_load || is_store)) begin
               out_valid     <= 1'b1;
               out_wreg_en   <= wreg_en;
               out_wreg_addr <= wreg_addr;
               out_wdata     <= result;
               out_adel      <= 1'b0;
               out_ades      <= 1'b0;
            end else if (misal) begin
               out_valid     <= 1'b1;
               out_wreg_en   <= 1'b0;
               out_wreg_addr <= wreg_addr;
               out_adel      <= is_load;
               out_ades      <= is_store;
               out_badvaddr  <= result;
            end else begin
               acc        <= '{op: memop, off: result[1:0], wreg_en: wreg_en, wreg_addr: wreg_addr};
               dmem_req   <= 1'b1;
               dmem_we    <= is_store;
               dmem_be    <= be_d;
               dmem_addr  <= {result[31:2], 2'b00};
               dmem_wdata <= wdata_d;
            end
         end else if (state == ACCESS && dmem_ack) begin
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            out_valid     <= 1'b1;
            out_wreg_en   <= acc_store ? 1'b0 : acc.wreg_en;
            out_wreg_addr <= acc.wreg_addr;
            out_wdata     <= acc_store ? 32'd0 : ld_val;
            out_adel      <= 1'b0;
            out_ades      <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed vector bench for mem_stage: table of single-instruction transactions plus reset/idle-ack sequences.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  memop;
   logic [31:0] result, store_data;
   logic        wreg_en;
   logic [4:0]  wreg_addr;
   logic        dmem_req, dmem_we;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        out_valid, out_wreg_en;
   logic [4:0]  out_wreg_addr;
   logic [31:0] out_wdata;
   logic        out_adel, out_ades;
   logic [31:0] out_badvaddr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .memop(memop), .result(result), .store_data(store_data),
      .wreg_en(wreg_en), .wreg_addr(wreg_addr),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .out_valid(out_valid), .out_wreg_en(out_wreg_en), .out_wreg_addr(out_wreg_addr),
      .out_wdata(out_wdata), .out_adel(out_adel), .out_ades(out_ades),
      .out_badvaddr(out_badvaddr)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] res;
      logic [31:0] sd;
      logic        wen;
      logic [4:0]  wad;
      logic [31:0] rdata;
      int          dly;
      logic        mem;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        owen;
      logic [31:0] owdata;
      logic        adel;
      logic        ades;
   } vec_t;

   localparam int NV = 16;
   vec_t vt [NV];

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk1({tag, " in_ready"}, in_ready, 1'b1);
      chk1({tag, " dmem_req"}, dmem_req, 1'b0);
      chk1({tag, " dmem_we"}, dmem_we, 1'b0);
      chk32({tag, " dmem_be"}, {28'd0, dmem_be}, 32'd0);
      chk32({tag, " dmem_addr"}, dmem_addr, 32'd0);
      chk32({tag, " dmem_wdata"}, dmem_wdata, 32'd0);
      chk1({tag, " out_valid"}, out_valid, 1'b0);
      chk1({tag, " out_wreg_en"}, out_wreg_en, 1'b0);
      chk32({tag, " out_wreg_addr"}, {27'd0, out_wreg_addr}, 32'd0);
      chk32({tag, " out_wdata"}, out_wdata, 32'd0);
      chk1({tag, " out_adel"}, out_adel, 1'b0);
      chk1({tag, " out_ades"}, out_ades, 1'b0);
      chk32({tag, " out_badvaddr"}, out_badvaddr, 32'd0);
   endtask

   task automatic run_vec(input vec_t t, input int idx);
      string n;
      n = $sformatf("v%0d", idx);
      @(negedge clk);
      chk1({n, " in_ready_pre"}, in_ready, 1'b1);
      memop = t.op; result = t.res; store_data = t.sd;
      wreg_en = t.wen; wreg_addr = t.wad; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; memop = 4'd0; result = 32'd0; store_data = 32'd0;
      if (t.mem) begin
         chk1({n, " req"}, dmem_req, 1'b1);
         chk1({n, " we"}, dmem_we, t.we);
         chk32({n, " be"}, {28'd0, dmem_be}, {28'd0, t.be});
         chk32({n, " addr"}, dmem_addr, t.addr);
         if (t.we) chk32({n, " dmem_wdata"}, dmem_wdata, t.wdata);
         chk1({n, " in_ready_busy"}, in_ready, 1'b0);
         chk1({n, " no_early_valid"}, out_valid, 1'b0);
         for (int k = 0; k < t.dly; k++) begin
            @(negedge clk);
            chk1({n, $sformatf(" wait%0d req", k)}, dmem_req, 1'b1);
            chk32({n, $sformatf(" wait%0d addr", k)}, dmem_addr, t.addr);
            chk1({n, $sformatf(" wait%0d in_ready", k)}, in_ready, 1'b0);
            chk1({n, $sformatf(" wait%0d out_valid", k)}, out_valid, 1'b0);
         end
         dmem_ack = 1'b1; dmem_rdata = t.rdata;
         @(negedge clk);
         dmem_ack = 1'b0; dmem_rdata = 32'd0;
      end
      chk1({n, " req_after"}, dmem_req, 1'b0);
      chk1({n, " out_valid"}, out_valid, 1'b1);
      chk1({n, " in_ready_post"}, in_ready, 1'b1);
      chk1({n, " out_wreg_en"}, out_wreg_en, t.owen);
      chk1({n, " adel"}, out_adel, t.adel);
      chk1({n, " ades"}, out_ades, t.ades);
      if (t.adel || t.ades) begin
         chk32({n, " badvaddr"}, out_badvaddr, t.res);
      end else begin
         chk32({n, " out_wdata"}, out_wdata, t.owdata);
         chk32({n, " out_wreg_addr"}, {27'd0, out_wreg_addr}, {27'd0, t.wad});
      end
      @(negedge clk);
      chk1({n, " pulse_end"}, out_valid, 1'b0);
      chk1({n, " req_idle"}, dmem_req, 1'b0);
   endtask

   initial begin
      //        op    res           sd            wen  wad    rdata         dly mem we  be       addr          wdata         owen owdata        adel ades
      vt[0]  = '{4'd0, 32'h1234_5678, 32'h0,        1'b1, 5'd5,  32'h0,        0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b1, 32'h1234_5678, 1'b0, 1'b0};
      vt[1]  = '{4'd1, 32'h0000_1003, 32'h0,        1'b1, 5'd7,  32'h80FF_7F01, 0, 1'b1, 1'b0, 4'b1111, 32'h0000_1000, 32'h0,        1'b1, 32'hFFFF_FF80, 1'b0, 1'b0};
      vt[2]  = '{4'd2, 32'h0000_1003, 32'h0,        1'b1, 5'd8,  32'h80FF_7F01, 0, 1'b1, 1'b0, 4'b1111, 32'h0000_1000, 32'h0,        1'b1, 32'h0000_0080, 1'b0, 1'b0};
      vt[3]  = '{4'd3, 32'h0000_1002, 32'h0,        1'b1, 5'd9,  32'h80FF_7F01, 0, 1'b1, 1'b0, 4'b1111, 32'h0000_1000, 32'h0,        1'b1, 32'hFFFF_80FF, 1'b0, 1'b0};
      vt[4]  = '{4'd4, 32'h0000_1000, 32'h0,        1'b1, 5'd10, 32'h80FF_7F01, 1, 1'b1, 1'b0, 4'b1111, 32'h0000_1000, 32'h0,        1'b1, 32'h0000_7F01, 1'b0, 1'b0};
      vt[5]  = '{4'd5, 32'h0000_1000, 32'h0,        1'b1, 5'd11, 32'h80FF_7F01, 2, 1'b1, 1'b0, 4'b1111, 32'h0000_1000, 32'h0,        1'b1, 32'h80FF_7F01, 1'b0, 1'b0};
      vt[6]  = '{4'd1, 32'h0000_1001, 32'h0,        1'b0, 5'd12, 32'h80FF_7F01, 0, 1'b1, 1'b0, 4'b1111, 32'h0000_1000, 32'h0,        1'b0, 32'h0000_007F, 1'b0, 1'b0};
      vt[7]  = '{4'd6, 32'h0000_2001, 32'hAABB_CCDD, 1'b1, 5'd13, 32'h0,        0, 1'b1, 1'b1, 4'b0010, 32'h0000_2000, 32'hDDDD_DDDD, 1'b0, 32'h0,         1'b0, 1'b0};
      vt[8]  = '{4'd7, 32'h0000_2002, 32'hAABB_CCDD, 1'b1, 5'd14, 32'h0,        0, 1'b1, 1'b1, 4'b1100, 32'h0000_2000, 32'hCCDD_CCDD, 1'b0, 32'h0,         1'b0, 1'b0};
      vt[9]  = '{4'd8, 32'h0000_2000, 32'hAABB_CCDD, 1'b1, 5'd15, 32'h0,        3, 1'b1, 1'b1, 4'b1111, 32'h0000_2000, 32'hAABB_CCDD, 1'b0, 32'h0,         1'b0, 1'b0};
      vt[10] = '{4'd5, 32'h0000_3002, 32'h0,        1'b1, 5'd16, 32'h0,        0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b0, 32'h0,         1'b1, 1'b0};
      vt[11] = '{4'd7, 32'h0000_3001, 32'h1111_2222, 1'b1, 5'd17, 32'h0,        0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b0, 32'h0,         1'b0, 1'b1};
      vt[12] = '{4'd12, 32'hDEAD_BEEF, 32'h0,       1'b0, 5'd18, 32'h0,        0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0};
      vt[13] = '{4'd4, 32'h0000_3001, 32'h0,        1'b1, 5'd19, 32'h0,        0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b0, 32'h0,         1'b1, 1'b0};
      vt[14] = '{4'd6, 32'h0000_2003, 32'h1122_3344, 1'b1, 5'd20, 32'h0,        0, 1'b1, 1'b1, 4'b1000, 32'h0000_2000, 32'h4444_4444, 1'b0, 32'h0,         1'b0, 1'b0};
      vt[15] = '{4'd8, 32'h0000_3006, 32'h5555_6666, 1'b1, 5'd21, 32'h0,        0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b0, 32'h0,         1'b0, 1'b1};

      rst_n = 1'b0; in_valid = 1'b0; memop = 4'd0; result = 32'd0; store_data = 32'd0;
      wreg_en = 1'b0; wreg_addr = 5'd0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) run_vec(vt[i], i);

      // Ack while idle must not produce a beat or a request.
      @(negedge clk);
      dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      dmem_ack = 1'b0;
      chk1("idle_ack out_valid", out_valid, 1'b0);
      chk1("idle_ack req", dmem_req, 1'b0);
      chk1("idle_ack in_ready", in_ready, 1'b1);

      // Reset while a load is outstanding, then a late ack.
      memop = 4'd5; result = 32'h0000_4000; wreg_en = 1'b1; wreg_addr = 5'd3; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; memop = 4'd0;
      chk1("mid_rst req_before", dmem_req, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_reset_outputs("mid_rst");
      dmem_ack = 1'b1; dmem_rdata = 32'h1234_ABCD;
      @(negedge clk);
      dmem_ack = 1'b0;
      chk1("late_ack out_valid", out_valid, 1'b0);
      chk1("late_ack req", dmem_req, 1'b0);
      chk1("late_ack in_ready", in_ready, 1'b1);
      @(negedge clk);
      check_reset_outputs("late_ack");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
